// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I single-cycle core.
// Serves the core's load/store port from an on-chip RAM with byte/half/word
// lane handling, and decodes a 16-byte MMIO window holding a keyboard
// scan-code FIFO, a millisecond timer and an LED register.
//
// Ports:
//   clock, reset       - system clock, asynchronous active-high reset
//   dmemaddr           - byte address from the core
//   dmemop             - funct3 access type
//   dmemwe, dmemre     - store enable, load qualifier (gates FIFO pops)
//   dmemdatain         - LSB-aligned store data
//   dmemdataout        - combinational load data, extended per dmemop
//   key_valid/key_data - scan-code strobe and value
//   led                - LED register
module dmem_responder #(
  parameter int unsigned RAM_AW       = 12,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned TICKS_PER_MS = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dmemaddr,
  input  logic [2:0]  dmemop,
  input  logic        dmemwe,
  input  logic        dmemre,
  input  logic [31:0] dmemdatain,
  output logic [31:0] dmemdataout,
  input  logic        key_valid,
  input  logic [7:0]  key_data,
  output logic [15:0] led
);

  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW     = PtrW + 1;
  localparam int unsigned RamWords = 1 << RAM_AW;

  logic [31:0]     ram_q [RamWords];
  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [31:0]     timer_q, timer_d, presc_q, presc_d;
  logic [15:0]     led_q, led_d;

  // Decode
  logic              ram_sel, mmio_sel, op_valid;
  logic [1:0]        reg_sel;
  logic [RAM_AW-1:0] word_idx;

  assign ram_sel  = (dmemaddr[31:20] == 12'h001);
  assign mmio_sel = (dmemaddr[31:4] == 28'h0020000);
  assign reg_sel  = dmemaddr[3:2];
  assign word_idx = dmemaddr[RAM_AW+1:2];

  always_comb begin
    unique case (dmemop)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: op_valid = 1'b1;
      default:                                op_valid = 1'b0;
    endcase
  end

  logic store_ok, ram_we, mmio_we, pop_req;
  assign store_ok = dmemwe && op_valid;
  assign ram_we   = store_ok && ram_sel;
  assign mmio_we  = store_ok && mmio_sel;
  assign pop_req  = dmemre && op_valid && mmio_sel && (reg_sel == 2'd1);

  // FIFO control
  logic fifo_empty, fifo_full, do_pop, do_push;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign do_pop     = pop_req && !fifo_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO proceeds.
  assign do_push    = key_valid && (!fifo_full || do_pop);

  // Load path (asynchronous RAM read, no store forwarding)
  logic [31:0] ram_rd, count_ext, key_status;
  logic [7:0]  ram_byte;
  logic [15:0] ram_half;
  logic [3:0]  cnt_sat;

  assign ram_rd     = ram_q[word_idx];
  assign ram_byte   = ram_rd[{dmemaddr[1:0], 3'b000} +: 8];
  assign ram_half   = ram_rd[{dmemaddr[1], 4'b0000} +: 16];
  assign count_ext  = 32'(count_q);
  assign cnt_sat    = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
  assign key_status = {24'b0, cnt_sat, 1'b0, overflow_q, fifo_full, !fifo_empty};

  always_comb begin
    dmemdataout = '0;
    if (op_valid && ram_sel) begin
      unique case (dmemop)
        3'b000:  dmemdataout = {{24{ram_byte[7]}}, ram_byte};
        3'b100:  dmemdataout = {24'b0, ram_byte};
        3'b001:  dmemdataout = {{16{ram_half[15]}}, ram_half};
        3'b101:  dmemdataout = {16'b0, ram_half};
        default: dmemdataout = ram_rd;
      endcase
    end else if (op_valid && mmio_sel) begin
      unique case (reg_sel)
        2'd0:    dmemdataout = key_status;
        2'd1:    dmemdataout = fifo_empty ? 32'h0 : {24'b0, fifo_q[rd_ptr_q]};
        2'd2:    dmemdataout = timer_q;
        default: dmemdataout = {16'b0, led_q};
      endcase
    end
  end

  // RAM store lanes
  logic [3:0]  byte_en;
  logic [31:0] wr_data;

  always_comb begin
    byte_en = '0;
    wr_data = dmemdatain;
    unique case (dmemop[1:0])
      2'b00: begin
        byte_en[dmemaddr[1:0]] = 1'b1;
        wr_data = {4{dmemdatain[7:0]}};
      end
      2'b01: begin
        byte_en = dmemaddr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{dmemdatain[15:0]}};
      end
      default: byte_en = 4'hF;
    endcase
  end

  always_ff @(posedge clock) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) ram_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) fifo_q[wr_ptr_q] <= key_data;
  end

  // Next-state logic
  logic presc_wrap;
  assign presc_wrap = (presc_q == 32'(TICKS_PER_MS - 1));

  always_comb begin
    wr_ptr_d   = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = do_pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (do_push && !do_pop) count_d = count_q + CntW'(1);
    if (do_pop && !do_push) count_d = count_q - CntW'(1);
    overflow_d = overflow_q;
    if (mmio_we && reg_sel == 2'd0) overflow_d = 1'b0;
    if (key_valid && fifo_full && !do_pop) overflow_d = 1'b1;
    presc_d    = presc_wrap ? 32'h0 : presc_q + 32'h1;
    timer_d    = presc_wrap ? timer_q + 32'h1 : timer_q;
    // A timer store overrides a coincident prescaler wrap.
    if (mmio_we && reg_sel == 2'd2) begin
      presc_d = '0;
      timer_d = '0;
    end
    led_d      = (mmio_we && reg_sel == 2'd3) ? dmemdatain[15:0] : led_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      timer_q    <= '0;
      presc_q    <= '0;
      led_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      timer_q    <= timer_d;
      presc_q    <= presc_d;
      led_q      <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM lanes, MMIO registers, key FIFO,
// timer prescaling and asynchronous reset behaviour.
module tb_dmem_responder;

  localparam logic [2:0] OpLb = 3'b000, OpLh = 3'b001, OpLw = 3'b010;
  localparam logic [2:0] OpLbu = 3'b100, OpLhu = 3'b101, OpBad = 3'b011;
  localparam logic [31:0] KeyStatus = 32'h0020_0000, KeyData = 32'h0020_0004;
  localparam logic [31:0] TimerReg = 32'h0020_0008, LedReg = 32'h0020_000C;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] dmemaddr, dmemdatain, dmemdataout;
  logic [2:0]  dmemop;
  logic        dmemwe, dmemre, key_valid;
  logic [7:0]  key_data;
  logic [15:0] led;

  int n_vec  = 0;
  int n_miss = 0;

  dmem_responder #(
    .RAM_AW      (12),
    .FIFO_DEPTH  (8),
    .TICKS_PER_MS(4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .dmemaddr   (dmemaddr),
    .dmemop     (dmemop),
    .dmemwe     (dmemwe),
    .dmemre     (dmemre),
    .dmemdatain (dmemdatain),
    .dmemdataout(dmemdataout),
    .key_valid  (key_valid),
    .key_data   (key_data),
    .led        (led)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [2:0] op, input logic [31:0] d);
    @(negedge clock);
    dmemaddr = a; dmemop = op; dmemdatain = d; dmemwe = 1'b1; dmemre = 1'b0;
    @(negedge clock);
    dmemwe = 1'b0;
  endtask

  task automatic chk_load(input string tag, input logic [31:0] a, input logic [2:0] op,
                          input logic re, input logic [31:0] exp);
    @(negedge clock);
    dmemaddr = a; dmemop = op; dmemre = re; dmemwe = 1'b0;
    #1 check_eq(tag, dmemdataout, exp);
    @(negedge clock);
    dmemre = 1'b0;
  endtask

  task automatic push_key(input logic [7:0] k);
    @(negedge clock);
    key_valid = 1'b1; key_data = k;
    @(negedge clock);
    key_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; dmemaddr = '0; dmemop = OpLw; dmemwe = 1'b0; dmemre = 1'b0;
    dmemdatain = '0; key_valid = 1'b0; key_data = '0;
    #2 reset = 1'b1;
    dmemaddr = KeyStatus;
    #1 check_eq("rst_led", {16'h0, led}, 32'h0);
    check_eq("rst_status", dmemdataout, 32'h0);
    dmemaddr = TimerReg;
    #1 check_eq("rst_timer", dmemdataout, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // RAM lanes
    do_store(32'h0010_0004, OpLw, 32'h89AB_CDEF);
    chk_load("lb_7",   32'h0010_0007, OpLb,  1'b0, 32'hFFFF_FF89);
    chk_load("lbu_7",  32'h0010_0007, OpLbu, 1'b0, 32'h0000_0089);
    chk_load("lh_6",   32'h0010_0006, OpLh,  1'b0, 32'hFFFF_89AB);
    chk_load("lhu_6",  32'h0010_0006, OpLhu, 1'b0, 32'h0000_89AB);
    chk_load("lh_7",   32'h0010_0007, OpLh,  1'b0, 32'hFFFF_89AB);
    chk_load("lb_6",   32'h0010_0006, OpLb,  1'b0, 32'hFFFF_FFAB);
    chk_load("lbu_4",  32'h0010_0004, OpLbu, 1'b0, 32'h0000_00EF);
    chk_load("lw_7",   32'h0010_0007, OpLw,  1'b0, 32'h89AB_CDEF);
    do_store(32'h0010_0005, OpLb, 32'hFFFF_FF55);
    chk_load("sb_lw",  32'h0010_0004, OpLw,  1'b0, 32'h89AB_55EF);
    do_store(32'h0010_0008, OpLw, 32'h1122_3344);
    do_store(32'h0010_000A, OpLh, 32'hDEAD_8001);
    chk_load("sh_lw",  32'h0010_0008, OpLw,  1'b0, 32'h8001_3344);
    chk_load("sh_lh",  32'h0010_000A, OpLh,  1'b0, 32'hFFFF_8001);
    chk_load("badop",  32'h0010_0004, OpBad, 1'b0, 32'h0);
    do_store(32'h0010_0004, OpBad, 32'h0);
    chk_load("badst",  32'h0010_0004, OpLw,  1'b0, 32'h89AB_55EF);
    chk_load("alias",  32'h0010_4004, OpLw,  1'b0, 32'h89AB_55EF);
    chk_load("unmap",  32'h0030_0004, OpLw,  1'b0, 32'h0);

    // LED
    do_store(LedReg, OpLw, 32'h1234_ABCD);
    check_eq("led_pin", {16'h0, led}, 32'h0000_ABCD);
    chk_load("led_rd", LedReg, OpLw, 1'b0, 32'h0000_ABCD);

    // Key FIFO basic
    push_key(8'h1C);
    push_key(8'h32);
    chk_load("st_two",  KeyStatus, OpLw, 1'b0, 32'h21);
    chk_load("peek",    KeyData,   OpLw, 1'b0, 32'h1C);
    chk_load("pop1",    KeyData,   OpLw, 1'b1, 32'h1C);
    chk_load("pop2",    KeyData,   OpLw, 1'b1, 32'h32);
    chk_load("pop_emp", KeyData,   OpLw, 1'b1, 32'h0);
    chk_load("st_emp",  KeyStatus, OpLw, 1'b0, 32'h00);

    // Overflow, simultaneous push+pop while full
    for (int i = 0; i < 9; i++) push_key(8'(8'h10 + i));
    chk_load("st_ovf", KeyStatus, OpLw, 1'b0, 32'h87);
    @(negedge clock);
    dmemaddr = KeyData; dmemop = OpLw; dmemre = 1'b1; key_valid = 1'b1; key_data = 8'h99;
    #1 check_eq("pp_head", dmemdataout, 32'h10);
    @(negedge clock);
    dmemre = 1'b0; key_valid = 1'b0;
    chk_load("st_pp",  KeyStatus, OpLw, 1'b0, 32'h87);
    do_store(KeyStatus, OpLw, 32'h0);
    chk_load("st_clr", KeyStatus, OpLw, 1'b0, 32'h83);
    for (int i = 0; i < 7; i++) chk_load("drain", KeyData, OpLw, 1'b1, 32'(8'h11 + i));
    chk_load("drain_last", KeyData,   OpLw, 1'b1, 32'h99);
    chk_load("st_drain",   KeyStatus, OpLw, 1'b0, 32'h00);

    // Asynchronous reset mid-operation
    push_key(8'h44);
    @(negedge clock);
    dmemaddr = KeyStatus; dmemop = OpLw;
    #2 reset = 1'b1;
    #1 check_eq("arst_led", {16'h0, led}, 32'h0);
    check_eq("arst_st", dmemdataout, 32'h0);
    key_valid = 1'b1; key_data = 8'h55;
    @(posedge clock);
    #1 key_valid = 1'b0;
    check_eq("rst_key", dmemdataout, 32'h0);
    dmemaddr = TimerReg;
    @(negedge clock);
    reset = 1'b0;

    // Timer: 4 ticks per ms
    repeat (10) @(posedge clock);
    #1 check_eq("timer10", dmemdataout, 32'h2);
    @(posedge clock);
    @(negedge clock);
    dmemdatain = 32'hFFFF_FFFF; dmemwe = 1'b1;
    @(posedge clock);
    #1 check_eq("tmr_wrap_st", dmemdataout, 32'h0);
    dmemwe = 1'b0;
    repeat (3) @(posedge clock);
    #1 check_eq("tmr_presc0", dmemdataout, 32'h0);
    @(posedge clock);
    #1 check_eq("tmr_tick", dmemdataout, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
